// File: rtl/pulse_shaper_mc.sv
// Multi-channel trigger pulse shaper: each channel turns a rising edge into a
// registered pulse of programmable width after a programmable delay.
module pulse_shaper_mc #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH-1:0]       retrig_mode,
  input  logic [NUM_CH*CNT_W-1:0] delay_cycles,
  input  logic [NUM_CH*CNT_W-1:0] width_cycles,
  input  logic [NUM_CH-1:0]       pulse_in,
  input  logic [NUM_CH-1:0]       drop_clr,
  output logic [NUM_CH-1:0]       pulse_out,
  output logic [NUM_CH-1:0]       busy,
  output logic [NUM_CH-1:0]       drop_flag
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DELAY  = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  state_t           state [NUM_CH];
  logic [CNT_W-1:0] cnt   [NUM_CH];
  logic [CNT_W-1:0] wlat  [NUM_CH];
  logic [CNT_W-1:0] d_ch  [NUM_CH];
  logic [CNT_W-1:0] w_ch  [NUM_CH];

  logic [NUM_CH-1:0] in_d1;
  logic [NUM_CH-1:0] trig;
  logic [NUM_CH-1:0] last;
  logic [NUM_CH-1:0] accept;
  logic [NUM_CH-1:0] drop_set;

  // A trigger in the final ACTIVE cycle is accepted regardless of mode so
  // that D=0 retriggers chain into a gap-free pulse.
  always_comb begin
    trig     = pulse_in & ~in_d1 & ch_en;
    last     = '0;
    accept   = '0;
    drop_set = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      d_ch[i]     = delay_cycles[i*CNT_W +: CNT_W];
      w_ch[i]     = width_cycles[i*CNT_W +: CNT_W];
      last[i]     = (state[i] == ACTIVE) && (cnt[i] == '0);
      accept[i]   = trig[i] && ((state[i] == IDLE) || retrig_mode[i] || last[i]);
      drop_set[i] = trig[i] && !accept[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_d1     <= '0;
      pulse_out <= '0;
      busy      <= '0;
      drop_flag <= '0;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state[i] <= IDLE;
        cnt[i]   <= '0;
        wlat[i]  <= '0;
      end
    end else begin
      in_d1 <= pulse_in;
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        drop_flag[i] <= drop_set[i] | (drop_flag[i] & ~drop_clr[i]);
        if (!ch_en[i]) begin
          state[i]     <= IDLE;
          cnt[i]       <= '0;
          pulse_out[i] <= 1'b0;
          busy[i]      <= 1'b0;
        end else if (accept[i]) begin
          wlat[i] <= w_ch[i];
          if (w_ch[i] == '0) begin
            state[i]     <= IDLE;
            cnt[i]       <= '0;
            pulse_out[i] <= 1'b0;
            busy[i]      <= 1'b0;
          end else if (d_ch[i] == '0) begin
            state[i]     <= ACTIVE;
            cnt[i]       <= w_ch[i] - CNT_W'(1);
            pulse_out[i] <= 1'b1;
            busy[i]      <= 1'b1;
          end else begin
            state[i]     <= DELAY;
            cnt[i]       <= d_ch[i] - CNT_W'(1);
            pulse_out[i] <= 1'b0;
            busy[i]      <= 1'b1;
          end
        end else begin
          unique case (state[i])
            DELAY: begin
              if (cnt[i] == '0) begin
                state[i]     <= ACTIVE;
                cnt[i]       <= wlat[i] - CNT_W'(1);
                pulse_out[i] <= 1'b1;
              end else begin
                cnt[i] <= cnt[i] - CNT_W'(1);
              end
            end
            ACTIVE: begin
              if (cnt[i] == '0) begin
                state[i]     <= IDLE;
                pulse_out[i] <= 1'b0;
                busy[i]      <= 1'b0;
              end else begin
                cnt[i] <= cnt[i] - CNT_W'(1);
              end
            end
            default: begin
              state[i] <= IDLE;
            end
          endcase
        end
      end
    end
  end

endmodule

// File: doc/pulse_shaper_mc.md
Name: pulse_shaper_mc

Overview:
- Multi-channel, parametrised successor to the single-channel pulse extender.
- Each channel detects a rising edge on its input, waits a runtime-programmable delay, then drives a registered output pulse of runtime-programmable width.
- Retrigger behaviour is selectable per channel; triggers that arrive while a channel is busy in non-retrigger mode are flagged as dropped.
- Sits between camera trigger/strobe sources and sensor or flash drive pins, typically fed from CSR registers.

Parameters:
- NUM_CH, 4, number of independent channels (1..32).
- CNT_W, 16, width of the delay and width counters; the maximum delay or width is 2^CNT_W-1 cycles.

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- ch_en  input  NUM_CH  per-channel enable. When low, the channel aborts and ignores triggers.
- retrig_mode  input  NUM_CH  per channel: 0 = ignore triggers while busy, 1 = restart on trigger.
- delay_cycles  input  NUM_CH*CNT_W  per-channel delay D. Channel i occupies bits [i*CNT_W +: CNT_W].
- width_cycles  input  NUM_CH*CNT_W  per-channel width W, same packing as delay_cycles.
- pulse_in  input  NUM_CH  trigger inputs, synchronous to clk.
- drop_clr  input  NUM_CH  single-cycle clear of the matching drop_flag bit.
- pulse_out  output  NUM_CH  shaped output pulses, registered.
- busy  output  NUM_CH  channel is in DELAY or ACTIVE, registered.
- drop_flag  output  NUM_CH  sticky flag: a trigger was ignored while the channel was busy.

Behaviour:
- Reset: the following are all 0 and every channel is in IDLE:
  - pulse_out, busy, drop_flag;
  - the edge-detect register in_d1;
  - all counters and latched-width registers.
- Trigger: trig[i] = pulse_in[i] & ~in_d1[i] & ch_en[i]. in_d1 updates every cycle regardless of ch_en. If pulse_in is already high when reset releases, a trigger fires on the first clock edge.
- D and W are sampled only at the accepted trigger edge. Changes to them mid-pulse have no effect until the next accepted trigger.
- Per-channel FSM, with k = the clock edge at which trig is seen:
  - IDLE:
    - trig with W=0 → stay in IDLE; no pulse is produced and no drop is flagged.
    - trig with D=0 → ACTIVE, cnt=W-1.
    - trig with D>0 → DELAY, cnt=D-1, W latched.
  - DELAY: cnt decrements each cycle. At cnt==0 → ACTIVE, cnt=W_latched-1.
  - ACTIVE: pulse_out=1 and cnt decrements each cycle. At cnt==0 → IDLE.
  - Result: pulse_out is high exactly W cycles, from edge k+D to edge k+D+W.
- busy = (state != IDLE). It is driven from the same registered state, so it is high from edge k to the edge at which the FSM leaves ACTIVE.
- Trigger while in DELAY or ACTIVE:
  - retrig_mode=1: restart exactly as from IDLE using the current D and W. In ACTIVE with D>0, pulse_out drops for the new delay period.
  - retrig_mode=0: the trigger is ignored and drop_flag is set.
  - Exception: a trigger arriving in the final ACTIVE cycle (cnt==0) is accepted in either mode and is not a drop. This gives back-to-back pulses with no low gap when D=0.
- A simultaneous drop_clr and drop-set on the same channel leaves drop_flag=1 (set wins).
- ch_en deasserted in any state → IDLE on the next edge; pulse_out and busy are 0 after that edge. drop_flag is unaffected.
- Reset asserted mid-pulse forces all outputs to 0 immediately, independent of clk.
- Channels are fully independent, with no shared state.
- Counter arithmetic is unsigned CNT_W-bit. Underflow cannot occur because cnt==0 always causes a state exit or reload.

Test Plan:
- Ch0 with D=0, W=3, mode 0; 1-cycle pulse_in at edge 10 → pulse_out high for edges 10–13 (3 cycles); busy for the same span; drop_flag=0.
- Ch1 with D=5, W=2; pulse_in held high for 20 cycles → exactly one pulse, high edges k+5..k+7. A long input produces no second trigger.
- Ch2 with D=0, W=8:
  - mode 0, second rising edge 3 cycles into the pulse → pulse still ends at k+8; drop_flag=1; drop_clr clears it.
  - Repeat with mode 1 → pulse ends at k2+8.
- Ch3 with D=0, W=4; second trigger lands exactly in the last ACTIVE cycle → continuous 8-cycle high; drop_flag=0.
- W=0 trigger → no pulse, busy stays 0, no drop.
- Deassert ch_en during DELAY → no pulse, busy=0 next cycle.
- Assert rst mid-pulse on all channels → all outputs 0 without waiting for clk.
- With pulse_in=1 at reset release → pulse on the first edge.
- All 4 channels triggered on the same cycle with different D/W (e.g. 1/1, 2/3, 0/5, 7/2) → each output matches its own timing independently.
